// File: rtl/pingpong_buffer_ctrl.sv
// Ping-pong buffer sequencer: fills one bank, drains it to the consumer, clears it, then swaps banks.
// Optional idle auto-flush is compiled in when PBUF_FLUSH_TIMEOUT_EN is defined.
module pingpong_buffer_ctrl #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             buf_sel,
    output logic             buf_en,
    output logic             buf_rd,
    output logic             buf_clr,
    input  logic             full0,
    input  logic             full1,
    input  logic [WIDTH-1:0] data_out0,
    input  logic [WIDTH-1:0] data_out1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [CNT_W-1:0] bank_count
);

    typedef enum logic [1:0] {INIT_CLR, FILL, DRAIN, CLEAR} state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    if ((2 ** CNT_W) <= DEPTH || TIMEOUT == 0) begin : g_param_check
        $error("pingpong_buffer_ctrl: CNT_W too narrow for DEPTH, or TIMEOUT is zero");
    end

    state_t           state_q, state_d;
    logic             buf_sel_q, buf_sel_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             stale_q, stale_d;
    logic             full_sel;
    logic             wr_fire;
    logic             auto_flush;

    assign in_ready = (state_q == FILL);
    assign wr_fire  = in_ready && in_valid;
    assign full_sel = buf_sel_q ? full1 : full0;

`ifdef PBUF_FLUSH_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    always_comb begin
        idle_d     = '0;
        auto_flush = 1'b0;
        if (state_q == FILL && !wr_fire && wr_cnt_q != '0) begin
            idle_d     = idle_q + IDLE_W'(1);
            auto_flush = (idle_d == IDLE_W'(TIMEOUT));
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) idle_q <= '0;
        else      idle_q <= idle_d;
    end
`else
    assign auto_flush = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        buf_sel_d = buf_sel_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        stale_d   = stale_q;
        buf_en    = 1'b0;
        buf_rd    = 1'b0;
        buf_clr   = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            INIT_CLR: begin
                buf_clr = 1'b1;
                state_d = FILL;
            end
            FILL: begin
                buf_en = wr_fire;
                if (wr_fire) wr_cnt_d = wr_cnt_q + CNT_W'(1);
                // Exit decisions use the post-write count so a flush alongside a write still drains it.
                if (wr_cnt_d != '0 &&
                    ((wr_fire && wr_cnt_d == DEPTH_C) || full_sel || flush || auto_flush)) begin
                    state_d = DRAIN;
                end else if (full_sel) begin
                    stale_d = 1'b1;
                    state_d = CLEAR;
                end
            end
            DRAIN: begin
                out_valid = (rd_cnt_q < wr_cnt_q);
                buf_rd    = out_valid && out_ready;
                if (buf_rd) begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    if (rd_cnt_d == wr_cnt_q) state_d = CLEAR;
                end
            end
            CLEAR: begin
                buf_clr = 1'b1;
                // A stale-full purge refills the same bank instead of swapping.
                if (!stale_q) buf_sel_d = ~buf_sel_q;
                stale_d  = 1'b0;
                wr_cnt_d = '0;
                rd_cnt_d = '0;
                state_d  = FILL;
            end
            default: state_d = INIT_CLR;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= INIT_CLR;
            buf_sel_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            stale_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_sel_q <= buf_sel_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            stale_q   <= stale_d;
        end
    end

    assign buf_sel    = buf_sel_q;
    assign out_data   = buf_sel_q ? data_out1 : data_out0;
    assign busy       = (state_q == DRAIN) || (state_q == CLEAR);
    assign bank_count = wr_cnt_q - rd_cnt_q;

endmodule

// File: doc/pingpong_buffer_ctrl.md
Name: pingpong_buffer_ctrl

Overview:
- Sequencer for the two-bank ping-pong buffer datapath.
- Accepts a valid/ready input stream and steers words into the selected bank (drives bufferSelect/EN), detects bank full, drains the filled bank to a valid/ready consumer (drives RD, muxes dataOut0/dataOut1), clears it, then swaps banks.
- Sits between the upstream producer, the parallel buffer and the downstream consumer.

Parameters:
- WIDTH, 16, data word width; matches the buffer data width.
- DEPTH, 16, words per bank.
- CNT_W, 5, counter width; must satisfy 2^CNT_W > DEPTH.
- TIMEOUT, 64, idle cycles before auto-flush (optional feature only).

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  producer word valid.
- in_ready  out  1  controller accepts a word.
- flush  in  1  request drain of a partially filled bank.
- buf_sel  out  1  to bufferSelect; 0 = bank0, 1 = bank1.
- buf_en  out  1  to EN; write strobe.
- buf_rd  out  1  to RD; read-advance strobe.
- buf_clr  out  1  to CLR.
- full0  in  1  FULL0 from buffer.
- full1  in  1  FULL1 from buffer.
- data_out0  in  WIDTH  dataOut0 from buffer.
- data_out1  in  WIDTH  dataOut1 from buffer.
- out_valid  out  1  word available to consumer.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  data_out0 when buf_sel=0, else data_out1; combinational.
- busy  out  1  high in DRAIN or CLEAR.
- bank_count  out  CNT_W  words currently held in the active bank.

Behaviour:
- States: INIT_CLR, FILL, DRAIN, CLEAR.
- Rst low (any time, including mid-drain): state=INIT_CLR, buf_sel=0, wr_cnt=0, rd_cnt=0. All outputs 0 except buf_clr, which is 1 in INIT_CLR.
- INIT_CLR: buf_clr=1 for exactly one cycle after Rst release, then -> FILL. This purges partial data left by a mid-operation reset.
- FILL:
  - in_ready=1. Write happens when in_valid&&in_ready; buf_en = in_valid&&in_ready, same cycle.
  - wr_cnt increments per write.
  - Exit -> DRAIN when any of these hold:
    - (a) a write brings wr_cnt to DEPTH;
    - (b) the full flag of the selected bank (full0 if buf_sel=0, else full1) is sampled high;
    - (c) flush=1 with wr_cnt>0 (post-write count).
  - flush with wr_cnt==0 and no write that cycle: ignored.
  - flush in the same cycle as a write: the word is written and counted, then drained.
- DRAIN:
  - in_ready=0. out_valid=1 while rd_cnt<wr_cnt.
  - buf_rd = out_valid&&out_ready. Each accept increments rd_cnt. out_data is valid in the same cycle as out_valid.
  - Consumer stall (out_ready=0): out_valid and out_data hold, buf_rd=0.
  - When the last accept makes rd_cnt==wr_cnt -> CLEAR.
  - flush is ignored in DRAIN.
- CLEAR:
  - buf_clr=1 for one cycle. in_ready=0, out_valid=0.
  - Next cycle: buf_sel toggles, wr_cnt=rd_cnt=0, -> FILL.
- bank_count = wr_cnt - rd_cnt.
- busy = (state==DRAIN || state==CLEAR).
- Throughput: one word per cycle in FILL and in DRAIN; 1-cycle bubble per bank swap.
- Invariant: buf_en and buf_rd are never high in the same cycle.
- Full flag high while wr_cnt==0: no DRAIN entry. Treated as stale; the bank is cleared via CLEAR once, then FILL resumes on the same bank.

Optional Feature:
- Macro: PBUF_FLUSH_TIMEOUT_EN.
- Defined: an idle counter counts FILL cycles with wr_cnt>0 and no write. It resets on each write. On reaching TIMEOUT it acts as an internal flush: FILL -> DRAIN on the next edge.
- Undefined: no idle counter and no TIMEOUT parameter use; partial banks drain only via the flush input.

Test Plan:
- Reset release -> buf_clr=1 for exactly 1 cycle, then in_ready=1, buf_sel=0, out_valid=0, bank_count=0.
- 16 back-to-back words 0x0001..0x0010 with out_ready=1 -> 16 buf_en pulses on bank0, then 16 buf_rd pulses with out_data 0x0001..0x0010 in order, 1 buf_clr, buf_sel becomes 1.
- 5 words then flush=1 -> DRAIN of exactly 5 words, CLEAR, bank swap. flush with wr_cnt=0 -> no state change.
- During DRAIN, toggle out_ready 1,0,0,1 -> out_data holds across stall, buf_rd only on ready cycles, in_ready=0 throughout.
- Assert Rst low mid-DRAIN after 3 of 10 words -> all outputs reset asynchronously, INIT_CLR pulse on release, buf_sel=0.
- With PBUF_FLUSH_TIMEOUT_EN and TIMEOUT=64: write 3 words then idle -> DRAIN entered on the 64th idle cycle. Without the macro -> stays in FILL indefinitely.
